// File: rtl/motor_pos_pwm_ctrl.sv
// Closed-loop position controller: proportional error to PWM duty, settle detection,
// and stall fault for a quadrature-encoded DC motor.
module motor_pos_pwm_ctrl #(
  parameter int unsigned PWM_PERIOD     = 2400,
  parameter int unsigned KP             = 4,
  parameter int unsigned DUTY_MAX       = 2160,
  parameter int unsigned DEADBAND       = 2,
  parameter int unsigned SETTLE         = 4,
  parameter int unsigned STALL_LIMIT    = 50,
  parameter int unsigned COUNTS_PER_REV = 348
) (
  input  logic        clk_48,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_cyc,
  input  logic [11:0] cmd_pos,
  output logic        cmd_ready,
  input  logic [3:0]  cyc,
  input  logic [11:0] pos,
  output logic        pwm,
  output logic        motor_dir,
  output logic [11:0] duty,
  output logic        at_target,
  output logic        fault
);

  localparam int unsigned CntW    = $clog2(PWM_PERIOD);
  localparam int unsigned SettleW = $clog2(SETTLE + 1);
  localparam int unsigned StallW  = $clog2(STALL_LIMIT + 1);

  localparam logic [CntW-1:0]    CntLast    = CntW'(PWM_PERIOD - 1);
  localparam logic [12:0]        Cpr        = 13'(COUNTS_PER_REV);
  localparam logic [11:0]        PosMax     = 12'(COUNTS_PER_REV - 1);
  localparam logic [13:0]        Band       = 14'(DEADBAND);
  localparam logic [13:0]        Band2      = 14'(2 * DEADBAND);
  localparam logic [17:0]        Kp18       = 18'(KP);
  localparam logic [17:0]        DutyMax18  = 18'(DUTY_MAX);
  localparam logic [11:0]        DutyMax    = 12'(DUTY_MAX);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);
  localparam logic [StallW-1:0]  StallLast  = StallW'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {StIdle, StMove, StHold, StFault} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [12:0]         abs_q;
  logic [12:0]         target_q;
  logic [12:0]         last_pos_q;
  logic signed [13:0]  err_q;
  logic [SettleW-1:0]  settle_q;
  logic [StallW-1:0]   stall_q;
  logic [11:0]         duty_q;
  logic                dir_q;
  logic                at_target_q;
  logic                fault_q;
  logic                cmd_ready_q;

  logic        tick;
  logic        accept;
  logic [11:0] pos_clamped;
  logic [12:0] cmd_target;
  logic [13:0] err_mag;
  logic [17:0] prod;
  logic        in_band;
  logic        far;
  logic [11:0] duty_calc;
  logic        dir_calc;
  logic        stalled;

  assign tick        = (cnt_q == CntLast);
  assign accept      = cmd_valid && cmd_ready_q && enable;
  assign pos_clamped = (cmd_pos > PosMax) ? PosMax : cmd_pos;
  assign cmd_target  = 13'(cmd_cyc) * Cpr + 13'(pos_clamped);

  assign err_mag   = err_q[13] ? 14'(-err_q) : 14'(err_q);
  assign prod      = {4'd0, err_mag} * Kp18;
  assign in_band   = (err_mag <= Band);
  assign far       = (err_mag > Band2);
  assign duty_calc = in_band ? 12'd0 : ((prod >= DutyMax18) ? DutyMax : prod[11:0]);
  // Inside the deadband the last drive direction is kept to avoid chattering.
  assign dir_calc  = in_band ? dir_q : ~err_q[13];
  assign stalled   = (duty_calc == DutyMax) && (abs_q == last_pos_q);

  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      cnt_q <= '0;
      abs_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
      abs_q <= 13'(cyc) * Cpr + 13'(pos);
      err_q <= $signed({1'b0, target_q}) - $signed({1'b0, abs_q});
    end
  end

  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      target_q    <= '0;
      last_pos_q  <= '0;
      settle_q    <= '0;
      stall_q     <= '0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      at_target_q <= 1'b0;
      fault_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (tick) last_pos_q <= abs_q;
      if (!enable) begin
        state_q     <= StIdle;
        settle_q    <= '0;
        stall_q     <= '0;
        duty_q      <= '0;
        at_target_q <= 1'b0;
        fault_q     <= 1'b0;
        cmd_ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            duty_q <= '0;
            if (accept) begin
              target_q    <= cmd_target;
              state_q     <= StMove;
              cmd_ready_q <= 1'b0;
              settle_q    <= '0;
              stall_q     <= '0;
            end
          end
          StMove: begin
            if (tick) begin
              duty_q  <= duty_calc;
              dir_q   <= dir_calc;
              stall_q <= stalled ? stall_q + StallW'(1) : '0;
              if (stalled && stall_q == StallLast) begin
                state_q  <= StFault;
                fault_q  <= 1'b1;
                duty_q   <= '0;
              end else if (in_band) begin
                if (settle_q == SettleLast) begin
                  state_q     <= StHold;
                  at_target_q <= 1'b1;
                  cmd_ready_q <= 1'b1;
                  settle_q    <= '0;
                end else begin
                  settle_q <= settle_q + SettleW'(1);
                end
              end else begin
                settle_q <= '0;
              end
            end
          end
          StHold: begin
            if (tick) begin
              duty_q <= duty_calc;
              dir_q  <= dir_calc;
            end
            // A new command wins; the tick above still used the old target via err_q.
            if (accept || (tick && far)) begin
              if (accept) target_q <= cmd_target;
              state_q     <= StMove;
              at_target_q <= 1'b0;
              cmd_ready_q <= 1'b0;
              settle_q    <= '0;
              stall_q     <= '0;
            end
          end
          StFault: begin
            duty_q <= '0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // duty_q is forced to zero in IDLE and FAULT, which also silences pwm there.
  assign pwm       = (32'(cnt_q) < 32'(duty_q));
  assign duty      = duty_q;
  assign motor_dir = dir_q;
  assign at_target = at_target_q;
  assign fault     = fault_q;
  assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_motor_pos_pwm_ctrl.sv
// Directed bench for motor_pos_pwm_ctrl; duty/direction expectations go through a
// scoreboard queue and are compared at the PWM update tick.
module tb_motor_pos_pwm_ctrl;

  localparam int unsigned Period = 2400;

  logic        clk_48 = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_cyc = '0;
  logic [11:0] cmd_pos = '0;
  logic        cmd_ready;
  logic [3:0]  cyc = '0;
  logic [11:0] pos = '0;
  logic        pwm;
  logic        motor_dir;
  logic [11:0] duty;
  logic        at_target;
  logic        fault;

  motor_pos_pwm_ctrl #(
    .PWM_PERIOD (Period),
    .STALL_LIMIT(10)
  ) dut (
    .clk_48   (clk_48),
    .reset_n  (reset_n),
    .enable   (enable),
    .cmd_valid(cmd_valid),
    .cmd_cyc  (cmd_cyc),
    .cmd_pos  (cmd_pos),
    .cmd_ready(cmd_ready),
    .cyc      (cyc),
    .pos      (pos),
    .pwm      (pwm),
    .motor_dir(motor_dir),
    .duty     (duty),
    .at_target(at_target),
    .fault    (fault)
  );

  always #5 clk_48 = ~clk_48;

  // Reference PWM counter: zero during reset, wraps every Period cycles.
  int tb_cnt = 0;
  always @(posedge clk_48) begin
    if (!reset_n) tb_cnt <= 0;
    else tb_cnt <= (tb_cnt == Period - 1) ? 0 : tb_cnt + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic step();
    @(posedge clk_48);
    #1;
  endtask

  task automatic next_tick();
    step();
    while (tb_cnt != 0) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_empty: observed %0d expected none", got);
    end else begin
      e = sb.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic [11:0] p);
    cmd_cyc   = c;
    cmd_pos   = p;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int highs;

    // Reset state
    repeat (3) step();
    chk("rst_pwm", pwm, 0);
    chk("rst_duty", duty, 0);
    chk("rst_dir", motor_dir, 0);
    chk("rst_at_target", at_target, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // err = 358 - 100 = 258 -> duty 1032, forward
    reset_n = 1'b1;
    enable  = 1'b1;
    cyc = 4'd0; pos = 12'd100;
    send_cmd(4'd1, 12'd10);
    chk("move_cmd_ready", cmd_ready, 0);
    sb_push("p258_duty", 1032);
    sb_push("p258_dir", 1);
    next_tick();
    sb_check(duty);
    sb_check(motor_dir);
    highs = 0;
    for (int i = 0; i < Period; i++) begin
      if (pwm === 1'b1) highs++;
      if (i != Period - 1) step();
    end
    chk("p258_pwm_high", highs, 1032);

    // Reset while moving
    reset_n = 1'b0;
    step();
    chk("mrst_pwm", pwm, 0);
    chk("mrst_duty", duty, 0);
    chk("mrst_fault", fault, 0);
    chk("mrst_at_target", at_target, 0);
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_dir", motor_dir, 0);
    step();
    step();
    reset_n = 1'b1;

    // err = 0 - 50 -> duty 200, reverse
    cyc = 4'd0; pos = 12'd50;
    send_cmd(4'd0, 12'd0);
    sb_push("n50_duty", 200);
    sb_push("n50_dir", 0);
    next_tick();
    sb_check(duty);
    sb_check(motor_dir);

    // Saturated drive with frozen position -> stall fault
    enable = 1'b0;
    step();
    enable = 1'b1;
    cyc = 4'd0; pos = 12'd0;
    send_cmd(4'd5, 12'd300);
    sb_push("sat_duty", 2160);
    sb_push("sat_dir", 1);
    next_tick();
    sb_check(duty);
    sb_check(motor_dir);
    repeat (8) next_tick();
    chk("stall_early", fault, 0);
    for (int i = 0; i < 4; i++) begin
      if (fault === 1'b1) break;
      next_tick();
    end
    chk("stall_fault", fault, 1);
    chk("fault_duty", duty, 0);
    chk("fault_cmd_ready", cmd_ready, 0);
    step();
    chk("fault_pwm", pwm, 0);
    send_cmd(4'd0, 12'd0);
    step();
    chk("fault_ignores_cmd", fault, 1);
    chk("fault_ignores_ready", cmd_ready, 0);
    enable = 1'b0;
    step();
    chk("unfault_fault", fault, 0);
    chk("unfault_ready", cmd_ready, 1);

    // Settle: measured at target-2 for SETTLE ticks -> HOLD
    enable = 1'b1;
    cyc = 4'd0; pos = 12'd100;
    next_tick();
    send_cmd(4'd0, 12'd102);
    repeat (3) next_tick();
    chk("settle3_at_target", at_target, 0);
    chk("settle3_duty", duty, 0);
    next_tick();
    chk("hold_at_target", at_target, 1);
    chk("hold_cmd_ready", cmd_ready, 1);
    chk("hold_duty", duty, 0);
    pos = 12'd97;
    sb_push("leave_hold_duty", 20);
    sb_push("leave_hold_dir", 1);
    next_tick();
    sb_check(duty);
    sb_check(motor_dir);
    chk("leave_hold_at_target", at_target, 0);
    chk("leave_hold_ready", cmd_ready, 0);

    // cmd_pos 400 clamps to 347; a command during MOVE is dropped
    enable = 1'b0;
    step();
    enable = 1'b1;
    cyc = 4'd0; pos = 12'd0;
    next_tick();
    send_cmd(4'd0, 12'd400);
    send_cmd(4'd0, 12'd10);
    sb_push("clamp_duty", 1388);
    sb_push("clamp_dir", 1);
    sb_push("ignored_cmd_duty", 1388);
    next_tick();
    sb_check(duty);
    sb_check(motor_dir);
    next_tick();
    sb_check(duty);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motor_pos_pwm_ctrl.md
MOTOR_POS_PWM_CTRL -- requirements
Module: motor_pos_pwm_ctrl

Interface
REQ-001 Parameter PWM_PERIOD, default 2400, PWM period in clk_48 cycles (20 kHz).
REQ-002 Parameter KP, default 4, proportional gain, integer 1..15.
REQ-003 Parameter DUTY_MAX, default 2160, duty saturation limit; SHALL be < PWM_PERIOD.
REQ-004 Parameter DEADBAND, default 2, error band in counts treated as on-target.
REQ-005 Parameter SETTLE, default 4, consecutive in-band updates required to declare on-target.
REQ-006 Parameter STALL_LIMIT, default 50, saturated updates without position change before fault.
REQ-007 Parameter COUNTS_PER_REV, default 348, counts per motor revolution.
REQ-008 clk_48  in  1  system clock, 48 MHz.
REQ-009 reset_n  in  1  reset, synchronous, active-low.
REQ-010 enable  in  1  controller enable; low forces IDLE.
REQ-011 cmd_valid  in  1  target command valid.
REQ-012 cmd_cyc  in  4  target revolution count.
REQ-013 cmd_pos  in  12  target count within revolution.
REQ-014 cmd_ready  out  1  command acceptance allowed.
REQ-015 cyc  in  4  measured revolution count from quadrature decoder.
REQ-016 pos  in  12  measured count within revolution from quadrature decoder, 0..347.
REQ-017 pwm  out  1  motor drive PWM.
REQ-018 motor_dir  out  1  drive direction, 1 = increasing position.
REQ-019 duty  out  12  active duty value in clk_48 cycles.
REQ-020 at_target  out  1  position settled within DEADBAND.
REQ-021 fault  out  1  stall fault latched.

Function
REQ-022 Absolute position SHALL be cyc*COUNTS_PER_REV + pos, 13-bit unsigned, registered every cycle; target formed likewise from latched command.
REQ-023 Error SHALL be target minus absolute position, 14-bit signed, registered every cycle.
REQ-024 Command accepted on the cycle cmd_valid & cmd_ready & enable; cmd_pos > COUNTS_PER_REV-1 SHALL be clamped to COUNTS_PER_REV-1 when latched.
REQ-025 cmd_ready SHALL be 1 in IDLE and HOLD only, 0 in MOVE and FAULT.
REQ-026 PWM counter SHALL run 0..PWM_PERIOD-1 and wrap; the wrap cycle is the update tick.
REQ-027 At each tick: |err| <= DEADBAND -> duty 0, motor_dir unchanged; else duty = min(|err|*KP, DUTY_MAX), motor_dir = (err > 0); applied from counter value 0 of the next period.
REQ-028 pwm SHALL be 1 while counter < duty, else 0; pwm, duty SHALL be 0 in IDLE and FAULT.
REQ-029 States IDLE, MOVE, HOLD, FAULT; enable low in any state SHALL give IDLE on the next edge, clearing fault.
REQ-030 IDLE: accepted command -> MOVE.
REQ-031 MOVE: SETTLE consecutive ticks with |err| <= DEADBAND -> HOLD; any out-of-band tick restarts the settle count.
REQ-032 HOLD: at_target 1, regulation continues; |err| > 2*DEADBAND at a tick -> MOVE; accepted command -> MOVE with new target, at_target cleared same edge.
REQ-033 Stall: in MOVE, each tick with duty = DUTY_MAX and absolute position equal to its value at previous tick increments stall count, else count clears; count reaching STALL_LIMIT -> FAULT.
REQ-034 FAULT: fault 1, pwm 0, commands ignored, exit only via enable low.
REQ-035 Command and tick on the same cycle: command latched first, tick uses the old target.

Reset
REQ-036 reset_n low at a clk_48 edge SHALL force IDLE, target 0, PWM counter 0, settle and stall counts 0, pwm 0, duty 0, motor_dir 0, at_target 0, fault 0, cmd_ready 1, including mid-MOVE.

Verification
REQ-037 Reset 3 cycles during MOVE -> next edge pwm 0, duty 0, fault 0, at_target 0, cmd_ready 1.
REQ-038 Measured cyc 0 pos 100, command cyc 1 pos 10 -> err 258, after next wrap duty 1032, motor_dir 1, pwm high 1032 of 2400 cycles.
REQ-039 Measured 0, command cyc 5 pos 300 -> duty 2160 (saturated); measured cyc 0 pos 50, command 0 -> duty 200, motor_dir 0.
REQ-040 Measured held at target-2 for 4 ticks -> duty 0, HOLD, at_target 1, cmd_ready 1; measured moves to target-5 -> MOVE, at_target 0.
REQ-041 Saturated drive with pos frozen 50 ticks -> fault 1, pwm 0, cmd_valid ignored; enable low -> IDLE, fault 0.
REQ-042 Command cmd_pos 400 -> latched target pos 347; cmd_valid during MOVE -> not accepted, target unchanged.
